// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM burst arbiter.
// The two-way round-robin pick lives here so the arbiter stays a thin register wrapper.
package rom_arb_pkg;

    localparam int unsigned ROM_ADDR_W = 4;
    localparam int unsigned ROM_DATA_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } arb_state_e;

    // One-hot grant: a lone requester always wins; on a tie prio names the winner.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
        logic [1:0] gnt;
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; owns the priority pointer.
// advance is the handshake pulse that hands priority to the other requester.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic prio_q, prio_d;

    always_comb begin
        gnt    = rr_pick(req, prio_q);
        prio_d = prio_q;
        if (advance) begin
            // Requester 0 served -> 1 goes first next; requester 1 served -> 0.
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Two-port burst sequencer in front of the 16x16 ROM: one burst at a time,
// responses tagged with owner id and a last-word flag, aligned to the ROM's 1-cycle latency.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req0_len,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [ADDR_W-1:0] req1_len,
    output logic              req1_ready,

    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_last,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_id_q, rsp_last_q;

    logic              idle;
    logic              issue;
    logic              last_issue;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic              handshake;

    assign idle       = (state_q == ST_IDLE);
    assign issue      = (state_q == ST_ISSUE);
    assign last_issue = issue && (cnt_q == '0);

    // Requests are only visible to the arbiter in IDLE, so ready can never rise mid-burst.
    assign arb_req   = {req1_valid, req0_valid} & {2{idle}};
    assign handshake = |arb_gnt;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (handshake),
        .gnt     (arb_gnt)
    );

    assign req0_ready = arb_gnt[0];
    assign req1_ready = arb_gnt[1];

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_gnt[0]) begin
                    cur_addr_d = req0_addr;
                    cnt_d      = req0_len;
                    id_d       = 1'b0;
                    state_d    = ST_ISSUE;
                end else if (arb_gnt[1]) begin
                    cur_addr_d = req1_addr;
                    cnt_d      = req1_len;
                    id_d       = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Address wraps modulo the ROM depth through natural overflow.
                cur_addr_d = cur_addr_q + 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (last_issue) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            rsp_valid_q <= issue;
            rsp_id_q    <= id_q;
            rsp_last_q  <= last_issue;
        end
    end

    assign rom_r_en  = issue;
    assign rom_addr  = issue ? cur_addr_q : '0;
    assign busy      = issue;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rom_data;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter with a behavioural ROM and a response scoreboard.
module tb_rom_burst_arbiter;

    typedef struct packed {
        logic [15:0] data;
        logic        id;
        logic        last;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req0_len, req1_addr, req1_len;
    logic        req0_ready, req1_ready;
    logic        rom_r_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_last;
    logic        busy;

    logic [15:0] mem [16];
    logic [15:0] rom_q;

    rsp_t        exp_rsp_q [$];
    logic [3:0]  exp_addr_q [$];

    int n_checks;
    int n_fail;

    rom_burst_arbiter #(
        .ADDR_W (4),
        .DATA_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_len   (req0_len),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_len   (req1_len),
        .req1_ready (req1_ready),
        .rom_r_en   (rom_r_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ROM: data appears the cycle after r_en.
    always @(posedge clk) begin
        if (rom_r_en) rom_q <= mem[rom_addr];
    end
    assign rom_data = rom_q;

    function automatic void check(input string tag, input logic [31:0] obs,
                                  input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    task automatic push_burst(input int id, input logic [3:0] a, input logic [3:0] l);
        logic [3:0] ea;
        rsp_t       r;
        for (int i = 0; i <= int'(l); i++) begin
            ea      = a + 4'(i);
            r.data  = mem[ea];
            r.id    = 1'(id);
            r.last  = (i == int'(l));
            exp_addr_q.push_back(ea);
            exp_rsp_q.push_back(r);
        end
    endtask

    // Advance one clock and score whatever the DUT presents after the edge.
    task automatic tick();
        rsp_t       r;
        logic [3:0] ea;
        @(posedge clk);
        #1;
        if (busy) check("ready_in_issue", 32'({req0_ready, req1_ready}), 32'd0);
        if (rom_r_en) begin
            if (exp_addr_q.size() == 0) begin
                check("stray_issue", 32'(rom_r_en), 32'd0);
            end else begin
                ea = exp_addr_q.pop_front();
                check("rom_addr", 32'(rom_addr), 32'(ea));
            end
        end
        if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
                check("stray_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                r = exp_rsp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(r.data));
                check("rsp_id", 32'(rsp_id), 32'(r.id));
                check("rsp_last", 32'(rsp_last), 32'(r.last));
            end
        end
    endtask

    // Wait for a handshake, score the new burst, then step across the handshake edge.
    task automatic wait_hs(input bit drop, output int who, output int waited);
        who    = -1;
        waited = 0;
        for (int i = 0; i < 64 && who < 0; i++) begin
            #1;
            check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
            if (req0_valid && req0_ready) who = 0;
            else if (req1_valid && req1_ready) who = 1;
            if (who < 0) begin
                tick();
                waited++;
            end
        end
        if (who < 0) begin
            check("hs_timeout", 32'(req0_ready | req1_ready), 32'd1);
        end else begin
            if (who == 0) push_burst(0, req0_addr, req0_len);
            else          push_burst(1, req1_addr, req1_len);
            check("hs_idle_ren", 32'(rom_r_en), 32'd0);
            tick();
            if (drop && who == 0) req0_valid = 1'b0;
            if (drop && who == 1) req1_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 48 && (exp_rsp_q.size() != 0 || exp_addr_q.size() != 0); i++) begin
            tick();
        end
        check("drain_rsp", 32'(exp_rsp_q.size()), 32'd0);
        check("drain_addr", 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        int who;
        int waited;
        n_checks   = 0;
        n_fail     = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i * 16'h0111);
        mem[8]     = 16'hcafe;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req0_len   = '0;
        req1_addr  = '0;
        req1_len   = '0;

        tick();
        tick();
        check("rst_rom_r_en", 32'(rom_r_en), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_last", 32'(rsp_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        rst = 1'b0;
        tick();

        // Single one-word burst, latency 2 from handshake to response.
        req0_valid = 1'b1;
        req0_addr  = 4'd8;
        req0_len   = 4'd0;
        wait_hs(1'b1, who, waited);
        check("single_who", 32'(who), 32'd0);
        check("single_ren", 32'(rom_r_en), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        check("single_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        check("single_rsp_t2", 32'(rsp_valid), 32'd1);
        check("single_cafe", 32'(rsp_data), 32'h0000cafe);
        drain();

        // Wrap-around from 14.
        req1_valid = 1'b1;
        req1_addr  = 4'd14;
        req1_len   = 4'd3;
        wait_hs(1'b1, who, waited);
        check("wrap_who", 32'(who), 32'd1);
        drain();

        // Contention held valid: grants alternate.
        req0_addr  = 4'd4;
        req0_len   = 4'd1;
        req1_addr  = 4'd12;
        req1_len   = 4'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_hs(1'b0, who, waited);
            check("alt_who", 32'(who), 32'(k % 2));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Back-to-back full-length bursts from requester 0.
        req0_addr  = 4'd3;
        req0_len   = 4'd15;
        req0_valid = 1'b1;
        wait_hs(1'b0, who, waited);
        check("b2b_who0", 32'(who), 32'd0);
        wait_hs(1'b0, who, waited);
        req0_valid = 1'b0;
        check("b2b_who1", 32'(who), 32'd0);
        check("b2b_gap", 32'(waited), 32'd16);
        drain();

        // Requester 1 arrives mid-burst and must wait for IDLE.
        req0_addr  = 4'd0;
        req0_len   = 4'd4;
        req0_valid = 1'b1;
        wait_hs(1'b1, who, waited);
        req1_addr  = 4'd5;
        req1_len   = 4'd2;
        req1_valid = 1'b1;
        wait_hs(1'b1, who, waited);
        check("hold_who", 32'(who), 32'd1);
        check("hold_wait", 32'(waited), 32'd5);
        drain();
        for (int i = 0; i < 3; i++) tick();

        // Reset on the 3rd ISSUE cycle of a len=7 burst.
        req0_addr  = 4'd2;
        req0_len   = 4'd7;
        req0_valid = 1'b1;
        wait_hs(1'b1, who, waited);
        tick();
        tick();
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        exp_rsp_q.delete();
        exp_addr_q.delete();
        tick();
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ren", 32'(rom_r_en), 32'd0);
        check("mid_rsp_last", 32'(rsp_last), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // After reset prio is back to 0, then requester 1 completes normally.
        req0_addr  = 4'd10;
        req0_len   = 4'd1;
        req1_addr  = 4'd0;
        req1_len   = 4'd0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_hs(1'b1, who, waited);
        check("post_rst_who0", 32'(who), 32'd0);
        wait_hs(1'b1, who, waited);
        check("post_rst_who1", 32'(who), 32'd1);
        drain();
        for (int i = 0; i < 3; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Two-port round-robin arbiter and burst sequencer for the 16 x 16-bit `rom` block. Each requester posts a start address and burst length. The arbiter grants one burst at a time, drives the ROM's `r_en`/`addr` once per word, and returns the words on a shared response bus tagged with requester ID and a last-word flag. It sits between the ROM and its two clients, so neither client drives the ROM directly.

## Interface
Parameters:
- `ADDR_W`, 4, ROM address width; depth is 2**ADDR_W, and addresses wrap modulo depth.
- `DATA_W`, 16, ROM word width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 burst request.
- `req0_addr`  in  ADDR_W  requester 0 start address.
- `req0_len`  in  ADDR_W  requester 0 burst length minus 1 (0 → 1 word, 15 → 16 words).
- `req0_ready`  out  1  requester 0 burst accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_len`, `req1_ready`: same as above, for requester 1.
- `rom_r_en`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM address.
- `rom_data`  in  DATA_W  ROM registered read data, valid one cycle after `rom_r_en`.
- `rsp_valid`  out  1  response word valid; no backpressure, so the consumer must accept it.
- `rsp_data`  out  DATA_W  response word, equal to `rom_data` combinationally.
- `rsp_id`  out  1  requester that owns the current response word.
- `rsp_last`  out  1  final word of the burst.
- `busy`  out  1  a burst is issuing.

## Operation
- FSM has two states: IDLE and ISSUE.
- IDLE:
  - Winner is selected combinationally from the valid requesters.
  - If both requesters are valid, the winner is the requester named by the priority pointer `prio`.
  - Only the winner's `reqN_ready` is asserted.
  - A handshake occurs when `valid && ready`. On handshake, latch `cur_addr = reqN_addr`, `cnt = reqN_len` and `id = N`, set `prio` to the other requester, and go to ISSUE.
  - If no requester is valid, `prio` is unchanged.
- ISSUE:
  - Each cycle: `rom_r_en=1`, `rom_addr=cur_addr`, `busy=1`.
  - Next cycle: `cur_addr` increments modulo 2**ADDR_W (15 → 0), and `cnt` decrements.
  - When `cnt==0`, this is the last issue: set `last_issue`, then return to IDLE.
- Response pipeline: registers `rsp_valid <= rom_r_en`, `rsp_id <= id`, `rsp_last <= (state==ISSUE && cnt==0)`. This matches the 1-cycle ROM latency.
- `reqN_ready` is never asserted in ISSUE. Requests arriving during a burst wait; a requester must hold valid, addr and len stable until ready.
- Arbitration and the ISSUE counter together make `rsp_id` unambiguous: responses never interleave between bursts.

## Timing
- Reset values: `rom_r_en=0`, `rom_addr=0`, `reqN_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_last=0`, `busy=0`, state IDLE, `prio=0` (requester 0 first).
- Latency: handshake on edge T → first `rom_r_en` in cycle T+1 → first `rsp_valid` in cycle T+2.
- A burst of len+1 words holds `rsp_valid` high for len+1 consecutive cycles. `rsp_last` is high only on the final word.
- Back-to-back bursts leave exactly one IDLE cycle with `rom_r_en=0`. The prior burst's last response appears during that IDLE cycle and overlaps the next handshake.
- Wrap-around: start 14 with len 3 reads addresses 14, 15, 0, 1.
- Simultaneous valid from both requesters: `prio` decides. The loser is served next, if still valid, after the current burst completes.
- Reset mid-burst: the next cycle shows all outputs at reset values. No further `rsp_valid` appears, including the word in flight. `prio` returns to 0.
- `reqN_ready` is combinational from `reqN_valid` and `prio` in IDLE only. Nothing is combinational from `rom_data` except `rsp_data`.

## Structure
- Package `rom_arb_pkg`:
  - state enum `{ST_IDLE, ST_ISSUE}`;
  - defaults `ROM_ADDR_W=4`, `ROM_DATA_W=16`.
- Sub-module `rr_arb2`:
  - inputs: `clk`, `rst`, two request bits, `advance`;
  - outputs: one-hot grant;
  - owns `prio`; `advance` is the handshake pulse.
- Top-level `rom_burst_arbiter` holds the FSM, address/count registers and the response pipeline. The bench instantiates `rom` alongside it.

## Test plan
- Single burst: preload mem[i], then send req0 with addr=8, len=0 → one response, `rsp_data=16'hcafe`, `rsp_id=0`, `rsp_last=1`, arriving 2 cycles after the handshake.
- Full wrap: req1 with addr=14, len=3 → `rom_addr` sequence 14, 15, 0, 1; responses mem[14], mem[15], mem[0], mem[1]; `rsp_last` on the 4th word only.
- Contention: after reset, both requesters valid in the same cycle → req0 granted first (len=1), then req1 granted in the IDLE cycle after. Hold both valid repeatedly → grants alternate 0, 1, 0, 1.
- Back-to-back: req0 held valid with len=15 twice → 16 responses, one IDLE gap, then 16 more, all `rsp_id=0`.
- Reset mid-burst: assert `rst` on the 3rd ISSUE cycle of a len=7 burst → next cycle `rsp_valid=0`, `busy=0`, `rom_r_en=0`, and no stray responses. A following req1 with addr=0, len=0 completes normally.
- Hold check: req1 asserted during req0's burst → `req1_ready` stays 0 until IDLE, then handshakes once.
